// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, BCD time layout and time type for the alarm sequencer
package alarm_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;
  typedef logic [23:0] bcd_time_t;
  localparam int HH_HI = 20;
  localparam int HH_LO = 16;
  localparam int MM_HI = 12;
  localparam int MM_LO = 8;
  localparam int SS_HI = 4;
  localparam int SS_LO = 0;
endpackage

// File: rtl/alarm_sequencer_btn_edge.sv
// btn_edge: one-bit rising-edge detector; history clears on reset
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= rst ? 1'b0 : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: matches BCD time against the alarm set-point and sequences ring/snooze/stop
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int TIMER_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [23:0]        cur_time,
  input  logic [23:0]        alarm_time,
  input  logic               enable,
  input  logic               btn_snooze,
  input  logic               btn_stop,
  output logic               ring,
  output logic               blink,
  output logic [1:0]         state,
  output logic [1:0]         snooze_cnt,
  output logic [TIMER_W-1:0] remaining
);
  localparam logic [TIMER_W-1:0] RING_T   = TIMER_W'(RING_SECS);
  localparam logic [TIMER_W-1:0] SNOOZE_T = TIMER_W'(SNOOZE_SECS);
  localparam logic [1:0]         MAX_CNT  = 2'(MAX_SNOOZE);
  alarm_state_t st, n_st;
  logic [TIMER_W-1:0] n_rem;
  logic [1:0] n_cnt;
  logic n_blink, stop_e, snooze_e, match;
  bcd_time_t now_t, set_t;
  btn_edge u_stop   (.clk(clk), .rst(rst), .d(btn_stop),   .rise(stop_e));
  btn_edge u_snooze (.clk(clk), .rst(rst), .d(btn_snooze), .rise(snooze_e));
  assign now_t = cur_time;
  assign set_t = alarm_time;
  assign match = tick && (now_t == set_t);
  // Stop and timeout share one exit: back to ARMED with the event fully cleared.
  always_comb begin
    n_st    = st;
    n_rem   = remaining;
    n_cnt   = snooze_cnt;
    n_blink = blink;
    if (!enable) begin
      n_st    = IDLE;
      n_rem   = '0;
      n_cnt   = '0;
      n_blink = 1'b0;
    end else begin
      unique case (st)
        IDLE: n_st = ARMED;
        ARMED: if (match) begin
          n_st    = RINGING;
          n_rem   = RING_T;
          n_cnt   = '0;
          n_blink = 1'b0;
        end
        RINGING: begin
          if (stop_e || (tick && remaining <= 1 && !(snooze_e && snooze_cnt < MAX_CNT))) begin
            n_st    = ARMED;
            n_rem   = '0;
            n_cnt   = '0;
            n_blink = 1'b0;
          end else if (snooze_e && snooze_cnt < MAX_CNT) begin
            n_st    = SNOOZE;
            n_rem   = SNOOZE_T;
            n_cnt   = snooze_cnt + 2'd1;
            n_blink = 1'b0;
          end else if (tick) begin
            n_rem   = remaining - 1'b1;
            n_blink = ~blink;
          end
        end
        SNOOZE: begin
          if (stop_e) begin
            n_st  = ARMED;
            n_rem = '0;
            n_cnt = '0;
          end else if (tick) begin
            n_st  = remaining > 1 ? SNOOZE : RINGING;
            n_rem = remaining > 1 ? remaining - 1'b1 : RING_T;
          end
          n_blink = 1'b0;
        end
        default: n_st = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      remaining  <= '0;
      snooze_cnt <= '0;
      blink      <= 1'b0;
    end else begin
      st         <= n_st;
      remaining  <= n_rem;
      snooze_cnt <= n_cnt;
      blink      <= n_blink;
    end
  end
  assign state = st;
  assign ring  = (st == RINGING);
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed self-checking bench for alarm_sequencer
module tb_alarm_sequencer;
  logic clk = 0;
  logic rst, tick, enable, btn_snooze, btn_stop;
  logic [23:0] cur_time, alarm_time;
  logic ring, blink;
  logic [1:0] state, snooze_cnt;
  logic [8:0] remaining;
  int tests = 0, fails = 0, toggles;
  logic prev_blink;
  alarm_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .cur_time(cur_time), .alarm_time(alarm_time),
    .enable(enable), .btn_snooze(btn_snooze), .btn_stop(btn_stop), .ring(ring),
    .blink(blink), .state(state), .snooze_cnt(snooze_cnt), .remaining(remaining)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int st, input int r, input int bl, input int cnt, input int rem);
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".ring"}, 32'(ring), r);
    chk({tag, ".blink"}, 32'(blink), bl);
    chk({tag, ".snooze_cnt"}, 32'(snooze_cnt), cnt);
    chk({tag, ".remaining"}, 32'(remaining), rem);
  endtask
  task automatic trigger();
    cur_time = 24'h070000;
    cyc(1);
    cur_time = 24'h070001;
  endtask
  initial begin
    rst = 1; enable = 0; tick = 0; btn_snooze = 0; btn_stop = 0;
    cur_time = 24'h000000; alarm_time = 24'h070000;
    cyc(0); cyc(0);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 0; enable = 1;
    cyc(0);
    chk_all("arm", 1, 0, 0, 0, 0);
    cur_time = 24'h065959;
    cyc(1);
    chk_all("nomatch", 1, 0, 0, 0, 0);
    trigger();
    chk_all("trigger", 2, 1, 0, 0, 60);
    toggles = 0;
    prev_blink = blink;
    for (int i = 0; i < 59; i++) begin
      cyc(1);
      if (blink !== prev_blink) toggles++;
      prev_blink = blink;
    end
    chk("blink_toggles", 32'(toggles), 59);
    chk_all("before_timeout", 2, 1, 1, 0, 1);
    cyc(1);
    chk_all("timeout", 1, 0, 0, 0, 0);
    trigger();
    chk_all("retrigger", 2, 1, 0, 0, 60);
    btn_snooze = 1;
    cyc(0);
    chk_all("snooze1", 3, 0, 0, 1, 300);
    btn_snooze = 0;
    cyc(0);
    for (int i = 0; i < 299; i++) cyc(1);
    chk_all("snooze_last", 3, 0, 0, 1, 1);
    cyc(1);
    chk_all("snooze_end", 2, 1, 0, 1, 60);
    for (int k = 0; k < 2; k++) begin
      btn_snooze = 1;
      cyc(0);
      btn_snooze = 0;
      cyc(0);
      for (int i = 0; i < 300; i++) cyc(1);
    end
    chk_all("after3", 2, 1, 0, 3, 60);
    btn_snooze = 1;
    cyc(1);
    chk_all("snooze_limit", 2, 1, 1, 3, 59);
    btn_snooze = 0;
    cyc(0);
    btn_stop = 1;
    cyc(0);
    chk_all("stop", 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0);
    trigger();
    for (int i = 0; i < 3; i++) cyc(0);
    chk_all("stop_held", 2, 1, 0, 0, 60);
    btn_stop = 0;
    cyc(0);
    btn_snooze = 1;
    cyc(1);
    chk_all("snooze_tick", 3, 0, 0, 1, 300);
    btn_snooze = 0;
    cyc(0);
    btn_stop = 1; btn_snooze = 1;
    cyc(1);
    chk_all("simul_snooze", 1, 0, 0, 0, 0);
    btn_stop = 0; btn_snooze = 0;
    cyc(0);
    trigger();
    cyc(1);
    btn_stop = 1; btn_snooze = 1;
    cyc(1);
    chk_all("simul_ring", 1, 0, 0, 0, 0);
    btn_stop = 0; btn_snooze = 0;
    cyc(0);
    trigger();
    btn_snooze = 1;
    cyc(0);
    btn_snooze = 0;
    cyc(1);
    chk_all("pre_disable", 3, 0, 0, 1, 299);
    enable = 0;
    cyc(0);
    chk_all("disable", 0, 0, 0, 0, 0);
    enable = 1;
    cyc(0);
    chk_all("rearm", 1, 0, 0, 0, 0);
    trigger();
    cyc(1);
    chk_all("pre_rst", 2, 1, 1, 0, 59);
    btn_stop = 1; rst = 1;
    cyc(0);
    chk_all("rst_ring", 0, 0, 0, 0, 0);
    rst = 0;
    cyc(0);
    chk_all("post_rst", 1, 0, 0, 0, 0);
    trigger();
    cyc(0);
    chk_all("no_stale_stop", 2, 1, 0, 0, 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
